// File: rtl/mealy_10011_overlap.sv
// Serial 1-0-0-1-1 detector: overlapping Mealy FSM with a combinational detect flag
// and a saturating match counter.
module mealy_10011_overlap #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x,
  output logic                 z,
  output logic [CNT_WIDTH-1:0] match_count
);

  // States are named by the matched prefix of the pattern.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = S0;
    z       = 1'b0;
    case (state_q)
      S0: state_d = x ? S1 : S0;
      S1: state_d = x ? S1 : S2;
      S2: state_d = x ? S1 : S3;
      S3: state_d = x ? S4 : S0;
      S4: begin
        // A completed match reuses its trailing '1'; a '0' keeps the "10" suffix.
        state_d = x ? S1 : S2;
        z       = x;
      end
      default: state_d = S0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (z && (count_q != {CNT_WIDTH{1'b1}})) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  assign match_count = count_q;

endmodule

// File: tb/tb_mealy_10011_overlap.sv
// Scoreboarded bench: a sliding-window reference model predicts z and both counters
// (8-bit and saturating 2-bit instances); a monitor compares every consumed bit.
module tb_mealy_10011_overlap;

  logic       clk;
  logic       reset;
  logic       x;
  logic       z8, z2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  mealy_10011_overlap #(.CNT_WIDTH(8)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .z           (z8),
    .match_count (cnt8)
  );

  mealy_10011_overlap #(.CNT_WIDTH(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .z           (z2),
    .match_count (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       z;
    logic [7:0] c8;
    logic [1:0] c2;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  logic hist[$];
  int   m_c8, m_c2;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: pattern is present when the last five bits since reset read 10011.
  task automatic model_bit(input logic b, input string tag);
    exp_t e;
    int   n;
    hist.push_back(b);
    n = hist.size();
    e.z = (n >= 5) && hist[n-5] && !hist[n-4] && !hist[n-3] && hist[n-2] && hist[n-1];
    if (e.z) begin
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3) m_c2++;
    end
    e.c8  = 8'(m_c8);
    e.c2  = 2'(m_c2);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic b, input string tag);
    @(negedge clk);
    x = b;
    model_bit(b, tag);
  endtask

  task automatic drive_seq(input logic [31:0] bits, input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) drive_bit(bits[i], tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    x     = 1'b1;
    hist.delete();
    m_c8 = 0;
    m_c2 = 0;
    #1;
    check("reset_z8", int'(z8), 0);
    check("reset_z2", int'(z2), 0);
    check("reset_cnt8", int'(cnt8), 0);
    check("reset_cnt2", int'(cnt2), 0);
    @(negedge clk);
    x     = 1'b0;
    reset = 1'b1;
  endtask

  // Monitor: z sampled just before the consuming edge, counters just after it.
  initial begin
    exp_t e;
    logic zs8, zs2;
    forever begin
      @(negedge clk);
      #4;
      if (exp_q.size() > 0 && reset) begin
        zs8 = z8;
        zs2 = z2;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.tag, "_z8"}, int'(zs8), int'(e.z));
        check({e.tag, "_z2"}, int'(zs2), int'(e.z));
        check({e.tag, "_cnt8"}, int'(cnt8), int'(e.c8));
        check({e.tag, "_cnt2"}, int'(cnt2), int'(e.c2));
      end
    end
  end

  initial begin
    reset = 1'b1;
    x     = 1'b0;
    m_c8  = 0;
    m_c2  = 0;
    #2;
    do_reset();

    drive_seq(32'b10011, 5, "basic");
    drive_seq(32'b10101, 5, "nonmatch");

    do_reset();
    drive_seq(32'b100110011, 9, "overlap");

    do_reset();
    drive_seq(32'b10010011, 8, "fallback");

    // Asynchronous reset while sitting in S4 with x=1.
    do_reset();
    drive_seq(32'b1001, 4, "midrst");
    @(negedge clk);
    x = 1'b1;
    #2;
    check("s4_x1_z8", int'(z8), 1);
    check("s4_x1_z2", int'(z2), 1);
    reset = 1'b0;
    hist.delete();
    m_c8 = 0;
    m_c2 = 0;
    #1;
    check("async_z8", int'(z8), 0);
    check("async_cnt8", int'(cnt8), 0);
    check("async_cnt2", int'(cnt2), 0);
    @(negedge clk);
    reset = 1'b1;
    model_bit(1'b1, "postrst");
    drive_seq(32'b0011, 4, "postrst");

    do_reset();
    drive_seq(32'b10011, 5, "sat");
    for (int i = 0; i < 4; i++) drive_seq(32'b0011, 4, "sat");

    do_reset();
    for (int i = 0; i < 400; i++) begin
      // Bias toward the pattern so detections and saturation occur often.
      if ($urandom_range(0, 3) == 0) drive_seq(32'b10011, 5, "rand");
      else drive_bit(1'($urandom_range(0, 1)), "rand");
    end

    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mealy_10011_overlap.md
Name: mealy_10011_overlap

Overview:
- Serial bit-stream pattern detector for the sequence 1-0-0-1-1, with x arriving MSB-first, one bit per clock.
- Implemented as a Mealy FSM with overlapping detection.
- z pulses combinationally in the cycle where the final '1' of the pattern is present on x.
- Includes a saturating match counter for monitoring; the block sits between a serial data source and downstream event logic.

Parameters:
- CNT_WIDTH, 8, width of match_count; must be at least 1.

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous active-low reset; 0 = reset asserted.
- x  input  1  serial data bit, sampled on the rising edge of clk.
- z  output  1  Mealy detect flag. High when the current state is S4 and x=1; purely combinational from state and x.
- match_count  output  CNT_WIDTH  registered count of detections; saturates at all-ones.

Behaviour:
- Reset:
  - reset=0 asynchronously forces state=S0 and match_count=0, independent of clk.
  - While held, z=0 regardless of x, because z requires S4.
  - Release is synchronous in effect: the first bit is sampled on the first rising edge with reset=1.
- State encoding: 3-bit register. Unused codes 5-7 must return to S0 on the next edge, with z=0 while in them.
- States, named by the matched prefix:
  - S0: nothing matched.
  - S1: "1".
  - S2: "10".
  - S3: "100".
  - S4: "1001".
- Transitions on each rising edge (x=0 / x=1):
  - S0 -> S0 / S1
  - S1 -> S2 / S1
  - S2 -> S3 / S1
  - S3 -> S0 / S4
  - S4 -> S2 / S1, with z=1 when x=1.
- Overlap rule:
  - After a detection the FSM goes to S1, so the trailing '1' is reused as the leading '1' of the next pattern.
  - From S4 with x=0, the suffix "10" is retained and the FSM goes to S2.
- z timing:
  - z is combinational (state==S4 && x==1) and is valid before the rising edge that consumes the final bit.
  - z glitches follow x with no registering.
  - Exactly one z cycle per completed pattern.
- match_count:
  - On a rising edge with reset=1 and z=1, increments by 1 unless already all-ones; there is no wrap-around.
  - Otherwise it holds.
- Reset mid-operation: an asynchronous reset at any state, including S4 with x=1, clears the state and counter immediately. The partial prefix is lost and no count is recorded for that edge.
- No other enables or handshakes; every rising edge out of reset consumes one bit.

Test Plan:
- Reset and basic detect:
  - Hold reset=0 with x=0 for 1 cycle, then release and drive x = 1,0,0,1,1 on successive cycles.
  - Required: z=0 for the first four bits and z=1 during the fifth bit; match_count=1 after that edge; state=S1.
- Non-match stream:
  - Continue directly after the detect with x = 1,0,1,0,1.
  - Required: z=0 throughout; match_count stays 1; final state S1.
- Overlap:
  - After reset, drive x = 1,0,0,1,1,0,0,1,1.
  - Required: z=1 on bit 5 and on bit 9; match_count=2.
- S4 fall-back:
  - Drive x = 1,0,0,1,0,0,1,1.
  - Required: after bit 5 the state is S2; z=1 only on bit 8; match_count=1.
- Async reset mid-pattern:
  - Drive x = 1,0,0,1, then assert reset=0 between clock edges while x=1.
  - Required: z drops to 0 immediately and match_count=0.
  - Then release reset, keep x=1, and drive 0,0,1,1. Required: z=1 only on the final bit.
- Saturation:
  - With CNT_WIDTH=2, drive 5 back-to-back overlapping patterns (1,0,0,1,1,0,0,1,1,...).
  - Required: match_count = 1,2,3,3,3; z still pulses for each detection.
